// File: rtl/sprite_motion_ctrl_if.sv
// Control and position bus between the sprite motion controller and its
// frame-timing / button source (master) and the address generator side.
interface sprite_motion_ctrl_if;
    localparam int unsigned POS_W = 10;

    logic             frame_tick;
    logic             manual;
    logic             btn_left;
    logic             btn_right;
    logic             btn_up;
    logic             btn_down;
    logic [POS_W-1:0] posx;
    logic [POS_W-1:0] posy;
    logic             dir_x;
    logic             dir_y;
    logic             update_done;
    logic             bounce_x;
    logic             bounce_y;

    modport master (
        output frame_tick, manual, btn_left, btn_right, btn_up, btn_down,
        input  posx, posy, dir_x, dir_y, update_done, bounce_x, bounce_y
    );

    modport slave (
        input  frame_tick, manual, btn_left, btn_right, btn_up, btn_down,
        output posx, posy, dir_x, dir_y, update_done, bounce_x, bounce_y
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: once per FRAME_DIV frames, moves the sprite
// either by auto-bounce or by buttons, committing both axes atomically.
module sprite_motion_ctrl #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned SPRITE_SIZE = 64,
    parameter int unsigned STEP        = 2,
    parameter int unsigned FRAME_DIV   = 1,
    parameter int unsigned INIT_X      = 288,
    parameter int unsigned INIT_Y      = 208
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_motion_ctrl_if.slave  bus
);
    localparam int unsigned PW = 10;
    localparam int unsigned AW = 11;
    localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [AW-1:0] XMAX = AW'(SCREEN_W - SPRITE_SIZE);
    localparam logic [AW-1:0] YMAX = AW'(SCREEN_H - SPRITE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_CALC_X, S_CALC_Y, S_COMMIT} state_t;

    state_t          r_state;
    logic [FW-1:0]   r_fdiv;
    logic [PW-1:0]   r_posx, r_posy, r_nx, r_ny;
    logic            r_dir_x, r_dir_y, r_ndx, r_ndy, r_bx, r_man;
    logic            r_update_done, r_bounce_x, r_bounce_y;
    logic [PW+1:0]   w_ax, w_ay;

    // One axis step at 11 bits; returns {bounce, dir, pos}.
    function automatic logic [PW+1:0] step_axis(input logic [AW-1:0] pos,
                                                input logic dir, input logic man,
                                                input logic inc, input logic dec,
                                                input logic [AW-1:0] maxv);
        logic [AW-1:0] up;
        logic [AW-1:0] np;
        logic          nd;
        logic          b;
        up = pos + AW'(STEP);
        np = pos;
        nd = dir;
        b  = 1'b0;
        if (man) begin
            if (inc && !dec)      np = (up > maxv) ? maxv : up;
            else if (dec && !inc) np = (pos < AW'(STEP)) ? '0 : pos - AW'(STEP);
        end else if (dir) begin
            if (up >= maxv) begin np = maxv; nd = 1'b0; b = 1'b1; end
            else                  np = up;
        end else begin
            if (pos <= AW'(STEP)) begin np = '0; nd = 1'b1; b = 1'b1; end
            else                  np = pos - AW'(STEP);
        end
        return {b, nd, PW'(np)};
    endfunction

    assign w_ax = step_axis(AW'(r_posx), r_dir_x, bus.manual, bus.btn_right, bus.btn_left, XMAX);
    assign w_ay = step_axis(AW'(r_posy), r_dir_y, r_man, bus.btn_down, bus.btn_up, YMAX);

    // Shadow registers hold the pending update until COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_fdiv        <= '0;
            r_posx        <= PW'(INIT_X);
            r_posy        <= PW'(INIT_Y);
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b1;
            r_nx          <= '0;
            r_ny          <= '0;
            r_ndx         <= 1'b0;
            r_ndy         <= 1'b0;
            r_bx          <= 1'b0;
            r_man         <= 1'b0;
            r_update_done <= 1'b0;
            r_bounce_x    <= 1'b0;
            r_bounce_y    <= 1'b0;
        end else begin
            r_update_done <= 1'b0;
            r_bounce_x    <= 1'b0;
            r_bounce_y    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_tick) begin
                        if (r_fdiv == FW'(FRAME_DIV - 1)) begin
                            r_fdiv  <= '0;
                            r_state <= S_CALC_X;
                        end else begin
                            r_fdiv  <= r_fdiv + FW'(1);
                        end
                    end
                end
                S_CALC_X: begin
                    r_man                 <= bus.manual;
                    {r_bx, r_ndx, r_nx}   <= w_ax;
                    r_state               <= S_CALC_Y;
                end
                S_CALC_Y: begin
                    {r_ndy, r_ny}         <= w_ay[PW:0];
                    r_update_done         <= 1'b1;
                    r_bounce_x            <= r_bx;
                    r_bounce_y            <= w_ay[PW+1];
                    r_state               <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_posx  <= r_nx;
                    r_posy  <= r_ny;
                    r_dir_x <= r_ndx;
                    r_dir_y <= r_ndy;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.posx        = r_posx;
    assign bus.posy        = r_posy;
    assign bus.dir_x       = r_dir_x;
    assign bus.dir_y       = r_dir_y;
    assign bus.update_done = r_update_done;
    assign bus.bounce_x    = r_bounce_x;
    assign bus.bounce_y    = r_bounce_y;
endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 Parameter SPRITE_SIZE, default 64, sprite edge length in pixels (64x64 sprite, 12-bit address space).
REQ-004 Parameter STEP, default 2, pixels moved per update.
REQ-005 Parameter FRAME_DIV, default 1, frames per position update (>=1).
REQ-006 Parameter INIT_X, default 288, and INIT_Y, default 208, reset position.
REQ-007 One clock; reset is asynchronous and active-low: clk input 1, rst_n input 1.
REQ-008 frame_tick input 1: one-cycle pulse at start of vertical blanking.
REQ-009 manual input 1: 1 = button mode, 0 = auto-bounce mode.
REQ-010 btn_left, btn_right, btn_up, btn_down input 1 each: synchronized level inputs.
REQ-011 posx, posy output 10 each: sprite top-left corner, consumed by the sprite address generator.
REQ-012 dir_x, dir_y output 1 each: 1 = right/down, 0 = left/up.
REQ-013 update_done, bounce_x, bounce_y output 1 each: single-cycle pulses.

Function
REQ-014 XMAX = SCREEN_W - SPRITE_SIZE (576), YMAX = SCREEN_H - SPRITE_SIZE (416); posx stays in [0, XMAX], posy in [0, YMAX] at all times.
REQ-015 FSM states IDLE, CALC_X, CALC_Y, COMMIT; IDLE->CALC_X on qualified tick; CALC_X->CALC_Y->COMMIT->IDLE unconditionally.
REQ-016 Frame divider fdiv counts frame_tick in IDLE only: if fdiv == FRAME_DIV-1, tick is qualified and fdiv wraps to 0; otherwise fdiv increments.
REQ-017 frame_tick outside IDLE is ignored and not counted.
REQ-018 Qualified tick in cycle T: CALC_X in T+1, CALC_Y in T+2, COMMIT in T+3, update_done high in T+3 only, new posx/posy/dir visible from T+4.
REQ-019 CALC_X/CALC_Y compute next values into shadow registers; posx, posy, dir_x, dir_y change only on the COMMIT->IDLE edge.
REQ-020 Auto, X axis, dir_x=1: if posx + STEP >= XMAX then next posx = XMAX, dir_x flips to 0, bounce_x pulses; else posx + STEP.
REQ-021 Auto, X axis, dir_x=0: if posx <= STEP then next posx = 0, dir_x flips to 1, bounce_x pulses; else posx - STEP.
REQ-022 Auto, Y axis: identical to REQ-020/021 using posy, YMAX, dir_y, bounce_y.
REQ-023 bounce_x/bounce_y pulse in the COMMIT cycle (T+3), together with update_done.
REQ-024 Manual: btn_right alone -> posx + STEP clamped to XMAX; btn_left alone -> posx - STEP clamped to 0; both or neither -> no X change.
REQ-025 Manual Y axis: same as REQ-024 with btn_down/btn_up, YMAX.
REQ-026 Manual: dir_x/dir_y hold; bounce pulses stay 0; buttons sampled in CALC_X (X) and CALC_Y (Y).
REQ-027 manual sampled once in CALC_X; change mid-update applies from the next update.
REQ-028 Arithmetic done at 11 bits; no wrap-around of posx/posy ever observed.

Reset
REQ-029 rst_n low forces immediately: state IDLE, fdiv 0, posx INIT_X, posy INIT_Y, dir_x 1, dir_y 1, update_done/bounce_x/bounce_y 0, shadow registers cleared.
REQ-030 Reset during CALC_X/CALC_Y/COMMIT aborts the update; no partial position change visible after release.
REQ-031 First qualified tick needs FRAME_DIV ticks after reset release.

Verification
REQ-032 Reset then auto, FRAME_DIV=1, one tick -> T+4: posx=290, posy=210, update_done high at T+3 only.
REQ-033 Auto, posx=575, dir_x=1, tick -> posx=576, dir_x=0, bounce_x pulse; next tick -> posx=574.
REQ-034 Auto, posy=1, dir_y=0, tick -> posy=0, dir_y=1, bounce_y pulse; next tick -> posy=2.
REQ-035 Manual, posx=1, btn_left -> posx=0; btn_left+btn_right -> posx unchanged; btn_down at posy=416 -> 416; no bounce pulses.
REQ-036 FRAME_DIV=3: ticks 1,2 no update, tick 3 update; extra tick in CALC_Y ignored and not counted.
REQ-037 rst_n low during CALC_Y -> posx=288, posy=208, state IDLE, no update_done.
